decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I/RV64I decode stage between fetch and execute.
- Replaces the purely combinational control decoder with a pipelined stage:
  - valid/ready handshake on both sides
  - full immediate generation
  - illegal-instruction detection
  - load-use hazard stall
  - flush
  - saturating stall counter
- One instruction is held in the output register; decoded control is launched one cycle after acceptance.

Parameters:
- XLEN, 32, datapath width; 32 or 64. Sets pc/imm width and sign-extension width.
- ALUOP_W, 4, width of the alu_op field.
- CNT_W, 16, width of the stall_cnt performance counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  pc of in_instr
- flush  in  1  kill held and incoming instruction (branch redirect)
- ex_mem_read  in  1  instruction now in execute is a load
- ex_rd  in  5  destination of that load
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg, op_sel  out  1 each  control bits; op_sel selects pc as ALU operand A
- alu_op  out  ALUOP_W  ALU operation, encoded per package
- mem_size  out  3  funct3 of the load/store
- imm  out  XLEN  sign-extended immediate
- rs1, rs2, rd  out  5 each  register indices
- pc_out  out  XLEN  registered pc
- illegal  out  1  unsupported encoding
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, all control bits 0, alu_op=0, imm=0, pc_out=0, illegal=0, stall_cnt=0.
  - Release is synchronous to the clk edge after rst_n rises.
  - Reset mid-transaction discards the held instruction.
- Hazard:
  - hz = in_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs1_in | (uses_rs2 & ex_rd==rs2_in)).
  - uses_rs2 is true for the R, S and B formats.
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~hz.
  - Transfer occurs when in_valid & in_ready.
  - Latency is 1 cycle: the bundle appears registered at the next edge.
  - While out_valid & ~out_ready, all outputs hold stable.
- Hazard stall: if hz and execute consumes the current bundle, out_valid drops to 0 next cycle (bubble).
- Flush:
  - Dominates; out_valid=0 at the next edge and no transfer occurs that cycle.
  - Takes effect even if out_ready=0.
  - Control bits are not cleared; only out_valid is cleared.
- Decode by opcode:
  - LUI: reg_write, alu_src, alu_op=PASSB.
  - AUIPC: reg_write, alu_src, op_sel, ADD.
  - JAL: reg_write, jump, op_sel, ADD.
  - JALR: reg_write, jump, alu_src, ADD; funct3!=0 is illegal.
  - BRANCH: branch, SUB for beq/bne, SLT for blt/bge, SLTU for bltu/bgeu; funct3 010/011 is illegal.
  - LOAD: reg_write, mem_read, alu_src, mem_to_reg, ADD; legal funct3 000,001,010,100,101.
  - STORE: mem_write, alu_src, ADD; legal funct3 000–010.
  - OP-IMM: reg_write, alu_src, op per funct3.
    - Shifts use funct7: 0000000 gives SLL/SRL; 0100000 with funct3 101 gives SRA.
    - For XLEN=32, instr[25] must be 0.
    - Other funct7 values are illegal.
  - OP: reg_write, op per funct3/funct7; funct7 other than 0000000/0100000 (sub/sra only) is illegal.
  - Any other opcode is illegal.
- Illegal instructions: all control bits 0, illegal=1, out_valid asserted so execute raises the trap.
- Immediates: I, S, B, U and J formats, sign-extended from instr[31] to XLEN.
- stall_cnt:
  - Increments each cycle hz=1.
  - Saturates at all-ones.
  - Cleared only by reset.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams
  - alu_op enum: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 PASSB=10
  - imm_fmt_e enum: I, S, B, U, J
  - ctrl_t packed struct holding the control bits
- Sub-module imm_gen (combinational, parametrised on XLEN); it is instantiated in the decode_stage.

Test Plan:
- Basic decode: addi x1,x2,5 (0x00510093), out_ready=1 → next cycle: out_valid=1, reg_write=1, alu_src=1, alu_op=ADD, imm=5, rs1=2, rd=1.
- Load-use: lw x3,8(x1) (0x0080A183) accepted, then add x4,x3,x5 (0x00518233) with ex_mem_read=1, ex_rd=3:
  - in_ready=0 for one cycle
  - one bubble (out_valid=0)
  - stall_cnt=1
  - add then issues.
- Branch decode: beq x1,x2,-4 (0xFE208EE3) → branch=1, alu_op=SUB, imm=0xFFFFFFFC (XLEN=32).
- Backpressure then SUB: hold out_ready=0 for 3 cycles with sub x1,x2,x3 (0x403100B3) held → outputs stable, in_ready=0; release → alu_op=SUB, next instruction accepted in the same cycle.
- Illegal plus flush:
  - 0xFFFFFFFF → illegal=1, all control bits 0.
  - flush asserted with out_ready=0 → out_valid=0 next cycle.
- Reset: assert rst_n=0 mid-stall with stall_cnt=7 → out_valid and stall_cnt go to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/rv_pkg.sv
// RV32I/RV64I decode definitions: opcodes, ALU op encoding, immediate formats, control bundle.
// No logic state; shared by the decode stage and its immediate generator.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
    logic mem_to_reg;
    logic op_sel;
  } ctrl_t;

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  // alt selects SUB/SRA for the funct3 codes that have an alternate form
  function automatic alu_op_e f3_alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator for I/S/B/U/J formats, sign-extended from instr[31] to XLEN.
// Purely combinational (zero latency); no flow control.
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage; bundle is registered one cycle after acceptance.
// in_ready drops while the held bundle is blocked or on a load-use hazard; flush kills held and incoming.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               jump,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               op_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         mem_size,
  output logic [XLEN-1:0]    imm,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic [XLEN-1:0]    pc_out,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1_in;
  logic [4:0] rs2_in;
  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign rs1_in = in_instr[19:15];
  assign rs2_in = in_instr[24:20];

  // instr[25] is shamt[5] on RV64 and must be clear on RV32
  logic sh_ok, sra_ok;
  assign sh_ok  = (in_instr[31:26] == 6'b000000) && ((XLEN == 64) || !in_instr[25]);
  assign sra_ok = (in_instr[31:26] == 6'b010000) && ((XLEN == 64) || !in_instr[25]);

  ctrl_t    ctrl_d;
  alu_op_e  aop_d;
  imm_fmt_e fmt_d;
  logic     ill_d;
  logic [2:0] ms_d;

  always_comb begin
    ctrl_d = '0;
    aop_d  = ALU_ADD;
    fmt_d  = IMM_I;
    ill_d  = 1'b0;
    case (opc)
      OPC_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        aop_d            = ALU_PASSB;
        fmt_d            = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.op_sel    = 1'b1;
        fmt_d            = IMM_U;
      end
      OPC_JAL: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jump      = 1'b1;
        ctrl_d.op_sel    = 1'b1;
        fmt_d            = IMM_J;
      end
      OPC_JALR: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jump      = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ill_d            = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl_d.branch = 1'b1;
        fmt_d         = IMM_B;
        case (f3[2:1])
          2'b00:   aop_d = ALU_SUB;
          2'b10:   aop_d = ALU_SLT;
          2'b11:   aop_d = ALU_SLTU;
          default: ill_d = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ill_d = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        fmt_d            = IMM_S;
        ill_d            = f3[2] || (f3 == 3'b011);
      end
      OPC_OPIMM: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        aop_d            = f3_alu_op(f3, 1'b0);
        if (f3 == 3'b001) begin
          ill_d = !sh_ok;
        end else if (f3 == 3'b101) begin
          if (sra_ok) aop_d = ALU_SRA;
          else        ill_d = !sh_ok;
        end
      end
      OPC_OP: begin
        ctrl_d.reg_write = 1'b1;
        aop_d            = f3_alu_op(f3, f7[5]);
        if (f7 == 7'b0100000) ill_d = (f3 != 3'b000) && (f3 != 3'b101);
        else                  ill_d = (f7 != 7'b0000000);
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) begin
      ctrl_d = '0;
      aop_d  = ALU_ADD;
    end
  end

  assign ms_d = (!ill_d && (opc == OPC_LOAD || opc == OPC_STORE)) ? f3 : 3'b000;

  logic [XLEN-1:0] imm_d;
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt_d),
    .imm   (imm_d)
  );

  logic hz, xfer;
  assign hz = in_valid && ex_mem_read && (ex_rd != 5'd0) &&
              ((ex_rd == rs1_in) || (uses_rs2(opc) && (ex_rd == rs2_in)));
  assign in_ready = (!out_valid || out_ready) && !hz;
  assign xfer     = in_valid && in_ready && !flush;

  ctrl_t ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      alu_op    <= '0;
      mem_size  <= '0;
      imm       <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      pc_out    <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      ctrl_q    <= ctrl_d;
      alu_op    <= ALUOP_W'(aop_d);
      mem_size  <= ms_d;
      imm       <= imm_d;
      rs1       <= rs1_in;
      rs2       <= rs2_in;
      rd        <= in_instr[11:7];
      pc_out    <= in_pc;
      illegal   <= ill_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stall_cnt <= '0;
    else if (hz && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign branch     = ctrl_q.branch;
  assign jump       = ctrl_q.jump;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign op_sel     = ctrl_q.op_sel;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with a queue scoreboard and an independent output monitor.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        flush = 1'b0, ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        out_valid, out_ready = 1'b1;
  logic        reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg, op_sel;
  logic [3:0]  alu_op;
  logic [2:0]  mem_size;
  logic [31:0] imm, pc_out;
  logic [4:0]  rs1, rs2, rd;
  logic        illegal;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ALUOP_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .op_sel(op_sel), .alu_op(alu_op), .mem_size(mem_size), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .pc_out(pc_out), .illegal(illegal),
    .stall_cnt(stall_cnt)
  );

  // ctrl order: reg_write mem_read mem_write branch jump alu_src mem_to_reg op_sel
  typedef struct packed {
    logic [7:0]  ctrl;
    logic [3:0]  op;
    logic [2:0]  ms;
    logic [31:0] im;
    logic        ic;
    logic [4:0]  r1, r2, rdx;
    logic [31:0] pc;
    logic        il;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t nil = '0;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic [7:0] c, input logic [3:0] op, input logic [2:0] ms,
                              input logic [31:0] im, input logic ic, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] rdx, input logic [31:0] pc,
                              input logic il);
    exp_t e;
    e = '{ctrl: c, op: op, ms: ms, im: im, ic: ic, r1: r1, r2: r2, rdx: rdx, pc: pc, il: il};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL spurious_out_valid: got out_valid=1 pc=0x%0h, expected no bundle (t=%0t)", pc_out, $time);
      end else begin
        mon_e = sb[0];
        chk("ctrl", {reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg, op_sel}, mon_e.ctrl);
        chk("alu_op", alu_op, mon_e.op);
        chk("mem_size", mem_size, mon_e.ms);
        if (mon_e.ic) chk("imm", imm, mon_e.im);
        chk("rs1", rs1, mon_e.r1);
        chk("rs2", rs2, mon_e.r2);
        chk("rd", rd, mon_e.rdx);
        chk("pc_out", pc_out, mon_e.pc);
        chk("illegal", illegal, mon_e.il);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // one cycle: drive at posedge+1, check in_ready at negedge, push expectation on a transfer
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic exr, input logic [4:0] exrd,
                      input logic exp_rdy, input exp_t e);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
    flush = fl; ex_mem_read = exr; ex_rd = exrd;
    @(negedge clk);
    chk("in_ready", in_ready, exp_rdy);
    if (v && exp_rdy && !fl) sb.push_back(e);
    @(posedge clk); #1;
    if (fl) sb.delete();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, nil);
  endtask

  localparam logic [31:0] I_ADDI = 32'h00510093, I_LUI  = 32'h800003B7, I_SRAI = 32'h4041D113;
  localparam logic [31:0] I_SLLI = 32'h02109093, I_SW   = 32'h0050A623, I_LW   = 32'h0080A183;
  localparam logic [31:0] I_ADD  = 32'h00518233, I_BEQ  = 32'hFE208EE3, I_SUB  = 32'h403100B3;
  localparam logic [31:0] I_OR   = 32'h007362B3, I_ILL  = 32'hFFFFFFFF;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl", {reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg, op_sel}, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_imm", imm, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;

    // single decodes and a back-to-back stream
    step(1, I_ADDI, 32'h100, 1, 0, 0, 0, 1, mk(8'b1000_0100, 4'd0, 3'd0, 32'd5, 1, 5'd2, 5'd5, 5'd1, 32'h100, 0));
    idle();
    step(1, I_LUI, 32'h104, 1, 0, 0, 0, 1, mk(8'b1000_0100, 4'd10, 3'd0, 32'h80000000, 1, 5'd0, 5'd0, 5'd7, 32'h104, 0));
    step(1, I_SRAI, 32'h108, 1, 0, 0, 0, 1, mk(8'b1000_0100, 4'd7, 3'd0, 32'h404, 1, 5'd3, 5'd4, 5'd2, 32'h108, 0));
    step(1, I_SLLI, 32'h10C, 1, 0, 0, 0, 1, mk(8'b0, 4'd0, 3'd0, 32'h0, 0, 5'd1, 5'd1, 5'd1, 32'h10C, 1));
    step(1, I_SW, 32'h110, 1, 0, 0, 0, 1, mk(8'b0010_0100, 4'd0, 3'd2, 32'd12, 1, 5'd1, 5'd5, 5'd12, 32'h110, 0));
    idle();

    // load-use: one stall cycle, one bubble, then the add issues
    step(1, I_LW, 32'h200, 1, 0, 0, 0, 1, mk(8'b1100_0110, 4'd0, 3'd2, 32'd8, 1, 5'd1, 5'd8, 5'd3, 32'h200, 0));
    step(1, I_ADD, 32'h204, 1, 0, 1, 5'd3, 0, nil);
    chk("bubble_out_valid", out_valid, 0);
    chk("stall_cnt_1", stall_cnt, 1);
    step(1, I_ADD, 32'h204, 1, 0, 0, 0, 1, mk(8'b1000_0000, 4'd0, 3'd0, 32'h0, 0, 5'd3, 5'd5, 5'd4, 32'h204, 0));
    idle();

    step(1, I_BEQ, 32'h300, 1, 0, 0, 0, 1, mk(8'b0001_0000, 4'd1, 3'd0, 32'hFFFFFFFC, 1, 5'd1, 5'd2, 5'd29, 32'h300, 0));
    idle();

    // backpressure: sub held for 3 cycles, or accepted in the release cycle
    step(1, I_SUB, 32'h400, 1, 0, 0, 0, 1, mk(8'b1000_0000, 4'd1, 3'd0, 32'h0, 0, 5'd2, 5'd3, 5'd1, 32'h400, 0));
    for (int i = 0; i < 3; i++) step(1, I_OR, 32'h404, 0, 0, 0, 0, 0, nil);
    step(1, I_OR, 32'h404, 1, 0, 0, 0, 1, mk(8'b1000_0000, 4'd3, 3'd0, 32'h0, 0, 5'd6, 5'd7, 5'd5, 32'h404, 0));
    idle();

    // illegal held under backpressure, then flushed; then flush kills an incoming instruction
    step(1, I_ILL, 32'h500, 1, 0, 0, 0, 1, mk(8'b0, 4'd0, 3'd0, 32'h0, 0, 5'd31, 5'd31, 5'd31, 32'h500, 1));
    step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, nil);
    step(0, 32'h0, 32'h0, 0, 1, 0, 0, 0, nil);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_keeps_illegal", illegal, 1);
    step(1, I_ADDI, 32'h504, 1, 1, 0, 0, 1, nil);
    chk("flush_incoming_killed", out_valid, 0);

    // accumulate 7 stall cycles total with a bundle held, then reset asynchronously
    step(1, I_ADDI, 32'h600, 1, 0, 0, 0, 1, mk(8'b1000_0100, 4'd0, 3'd0, 32'd5, 1, 5'd2, 5'd5, 5'd1, 32'h600, 0));
    for (int i = 0; i < 6; i++) step(1, I_ADD, 32'h604, 0, 0, 1, 5'd3, 0, nil);
    chk("stall_cnt_7", stall_cnt, 7);
    chk("held_out_valid", out_valid, 1);
    @(negedge clk);
    #2;
    in_valid = 1'b0; ex_mem_read = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_stall_cnt", stall_cnt, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    step(1, I_SW, 32'h700, 1, 0, 0, 0, 1, mk(8'b0010_0100, 4'd0, 3'd2, 32'd12, 1, 5'd1, 5'd5, 5'd12, 32'h700, 0));
    idle();
    idle();

    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending bundles, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
